// File: rtl/slurm_ctx_pkg.sv
// Shared constants and state encoding for the register context engine.
// Widths, the idle write-back register and the ABI register indices live here.
package slurm_ctx_pkg;

  localparam int REG_BITS  = 5;
  localparam int BITS      = 16;
  localparam int NUM_REGS  = 16;
  localparam int ADDR_BITS = 16;

  localparam logic [REG_BITS-1:0] IDLE_REG = REG_BITS'(31);

  localparam logic [REG_BITS-1:0] REG_FP  = REG_BITS'(12);
  localparam logic [REG_BITS-1:0] REG_SP  = REG_BITS'(13);
  localparam logic [REG_BITS-1:0] REG_ILR = REG_BITS'(14);
  localparam logic [REG_BITS-1:0] REG_LR  = REG_BITS'(15);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SV_SEL,
    ST_SV_CAP,
    ST_SV_REQ,
    ST_RS_REQ,
    ST_RS_WAIT,
    ST_RS_WR,
    ST_FIN
  } ctx_state_e;

endpackage

// File: rtl/reg_context_engine_if.sv
// Command, register-file and memory bus bundle of the context engine.
// slave is the engine side, master the surrounding pipeline/memory side.
interface reg_context_engine_if;
  import slurm_ctx_pkg::*;

  logic                 start_save;
  logic                 start_restore;
  logic [ADDR_BITS-1:0] base_addr;
  logic                 busy;
  logic                 done;
  logic [REG_BITS-1:0]  reg_rd_sel;
  logic [BITS-1:0]      reg_rd_data;
  logic [REG_BITS-1:0]  reg_wr_sel;
  logic [BITS-1:0]      reg_wr_data;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [BITS-1:0]      mem_wr_data;
  logic                 mem_wr;
  logic                 mem_rd;
  logic                 mem_ready;
  logic [BITS-1:0]      mem_rd_data;
  logic                 mem_rd_valid;

  modport slave (
    input  start_save, start_restore, base_addr,
    input  reg_rd_data, mem_ready, mem_rd_data, mem_rd_valid,
    output busy, done, reg_rd_sel, reg_wr_sel, reg_wr_data,
    output mem_addr, mem_wr_data, mem_wr, mem_rd
  );

  modport master (
    output start_save, start_restore, base_addr,
    output reg_rd_data, mem_ready, mem_rd_data, mem_rd_valid,
    input  busy, done, reg_rd_sel, reg_wr_sel, reg_wr_data,
    input  mem_addr, mem_wr_data, mem_wr, mem_rd
  );

endinterface

// File: rtl/ctx_addr_gen.sv
// Base latch, register index, compacted memory offset and last-register detect.
// REG_CONTEXT_MASK_EN: skip registers whose save_mask bit is clear.
module ctx_addr_gen
  import slurm_ctx_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 adv_i,
  input  logic [ADDR_BITS-1:0] base_i,
`ifdef REG_CONTEXT_MASK_EN
  input  logic [NUM_REGS-1:0]  mask_i,
`endif
  output logic [REG_BITS-1:0]  idx_o,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic                 last_o,
  output logic                 empty_o
);

  logic [ADDR_BITS-1:0] base_q, base_d;
  logic [ADDR_BITS-1:0] off_q, off_d;
  logic [REG_BITS-1:0]  idx_q, idx_d;
  logic [REG_BITS-1:0]  first;
  logic [REG_BITS-1:0]  next;

`ifdef REG_CONTEXT_MASK_EN
  logic [NUM_REGS-1:0] mask_q, mask_d;

  function automatic logic [REG_BITS-1:0] find_set(
    input logic [NUM_REGS-1:0] m,
    input logic [REG_BITS-1:0] from
  );
    logic [REG_BITS-1:0] r;
    r = REG_BITS'(NUM_REGS);
    for (int i = NUM_REGS - 1; i >= 0; i--)
      if (m[i] && (REG_BITS'(i) >= from)) r = REG_BITS'(i);
    return r;
  endfunction

  assign first   = find_set(mask_i, '0);
  assign next    = find_set(mask_q, idx_q + 1'b1);
  assign last_o  = (next == REG_BITS'(NUM_REGS));
  assign empty_o = (mask_q == '0);
`else
  assign first   = '0;
  assign next    = idx_q + 1'b1;
  assign last_o  = (idx_q == REG_BITS'(NUM_REGS - 1));
  assign empty_o = 1'b0;
`endif

  assign idx_o  = idx_q;
  assign addr_o = base_q + off_q;

  // Load on start, step index and compacted offset on each transfer.
  always_comb begin
    base_d = base_q;
    off_d  = off_q;
    idx_d  = idx_q;
`ifdef REG_CONTEXT_MASK_EN
    mask_d = mask_q;
`endif
    if (load_i) begin
      base_d = base_i;
      off_d  = '0;
      idx_d  = first;
`ifdef REG_CONTEXT_MASK_EN
      mask_d = mask_i;
`endif
    end else if (adv_i) begin
      off_d = off_q + 1'b1;
      idx_d = next;
    end
  end

  // Pointer state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q <= '0;
      off_q  <= '0;
      idx_q  <= '0;
`ifdef REG_CONTEXT_MASK_EN
      mask_q <= '0;
`endif
    end else begin
      base_q <= base_d;
      off_q  <= off_d;
      idx_q  <= idx_d;
`ifdef REG_CONTEXT_MASK_EN
      mask_q <= mask_d;
`endif
    end
  end

endmodule

// File: rtl/reg_context_engine.sv
// Saves/restores R0..R15 between the register file and data memory.
// REG_CONTEXT_MASK_EN adds save_mask to transfer a subset of registers.
module reg_context_engine
  import slurm_ctx_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
`ifdef REG_CONTEXT_MASK_EN
  input  logic [NUM_REGS-1:0] save_mask,
`endif
  reg_context_engine_if.slave bus
);

  ctx_state_e           state_q, state_d;
  logic [BITS-1:0]      wdat_q, wdat_d;
  logic [BITS-1:0]      rdat_q, rdat_d;
  logic                 load, adv;
  logic                 last, empty;
  logic [REG_BITS-1:0]  idx;
  logic [ADDR_BITS-1:0] addr;

  ctx_addr_gen u_addr (
    .clk_i   (CLK),
    .rst_i   (RST),
    .load_i  (load),
    .adv_i   (adv),
    .base_i  (bus.base_addr),
`ifdef REG_CONTEXT_MASK_EN
    .mask_i  (save_mask),
`endif
    .idx_o   (idx),
    .addr_o  (addr),
    .last_o  (last),
    .empty_o (empty)
  );

  assign bus.mem_wr_data = wdat_q;

  // Next state and per-state bus/register-file drive.
  always_comb begin
    state_d         = state_q;
    wdat_d          = wdat_q;
    rdat_d          = rdat_q;
    load            = 1'b0;
    adv             = 1'b0;
    bus.busy        = (state_q != ST_IDLE) && (state_q != ST_FIN);
    bus.done        = (state_q == ST_FIN);
    bus.reg_rd_sel  = '0;
    bus.reg_wr_sel  = IDLE_REG;
    bus.reg_wr_data = '0;
    bus.mem_addr    = '0;
    bus.mem_wr      = 1'b0;
    bus.mem_rd      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_save) begin
          load    = 1'b1;
          state_d = ST_SV_SEL;
        end else if (bus.start_restore) begin
          load    = 1'b1;
          state_d = ST_RS_REQ;
        end
      end
      ST_SV_SEL: begin
        bus.reg_rd_sel = idx;
        state_d = empty ? ST_FIN : ST_SV_CAP;
      end
      ST_SV_CAP: begin
        wdat_d  = bus.reg_rd_data;
        state_d = ST_SV_REQ;
      end
      ST_SV_REQ: begin
        bus.mem_wr   = 1'b1;
        bus.mem_addr = addr;
        if (bus.mem_ready) begin
          adv     = !last;
          state_d = last ? ST_FIN : ST_SV_SEL;
        end
      end
      ST_RS_REQ: begin
        if (empty) begin
          state_d = ST_FIN;
        end else begin
          bus.mem_rd   = 1'b1;
          bus.mem_addr = addr;
          if (bus.mem_ready) state_d = ST_RS_WAIT;
        end
      end
      ST_RS_WAIT: begin
        if (bus.mem_rd_valid) begin
          rdat_d  = bus.mem_rd_data;
          state_d = ST_RS_WR;
        end
      end
      ST_RS_WR: begin
        bus.reg_wr_sel  = idx;
        bus.reg_wr_data = rdat_q;
        adv     = !last;
        state_d = last ? ST_FIN : ST_RS_REQ;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, store data and load data registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      wdat_q  <= '0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
    end
  end

endmodule

// File: tb/tb_reg_context_engine.sv
// Directed bench for reg_context_engine with register-file and memory models.
module tb_reg_context_engine;
  import slurm_ctx_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  reg_context_engine_if bus ();

`ifdef REG_CONTEXT_MASK_EN
  logic [NUM_REGS-1:0] mask = '1;
`endif

  reg_context_engine dut (
    .CLK       (CLK),
    .RST       (RST),
`ifdef REG_CONTEXT_MASK_EN
    .save_mask (mask),
`endif
    .bus       (bus.slave)
  );

  logic [15:0] rf  [32];
  logic [15:0] mem [65536];
  logic [15:0] st_addr [$];
  logic [15:0] st_data [$];
  bit rf_pre  = 1'b0;
  bit mem_pre = 1'b0;
  int cyc = 0, done_cnt = 0, wsel_cnt = 0, rd_cnt = 0;
  int done_at = 0, start_at = 0;
  int checks = 0, failures = 0;
  int s0, d0, w0, r0, n;

  // Register file: 1-cycle registered read, unconditional write.
  always @(posedge CLK) begin
    if (rf_pre)
      for (int i = 0; i < 16; i++) rf[i] <= 16'h1000 + 16'(i);
    rf[bus.reg_wr_sel] <= bus.reg_wr_data;
    bus.reg_rd_data <= rf[bus.reg_rd_sel];
  end

  // Memory with 1-cycle read valid, plus traffic monitor.
  always @(posedge CLK) begin
    if (mem_pre)
      for (int i = 0; i < 16; i++) mem[16'h0300 + i] <= 16'hA000 + 16'(i);
    if (bus.mem_wr && bus.mem_ready) begin
      mem[bus.mem_addr] <= bus.mem_wr_data;
      st_addr.push_back(bus.mem_addr);
      st_data.push_back(bus.mem_wr_data);
    end
    bus.mem_rd_valid <= bus.mem_rd && bus.mem_ready;
    bus.mem_rd_data  <= mem[bus.mem_addr];
    if (bus.mem_rd && bus.mem_ready) rd_cnt++;
    if (bus.reg_wr_sel != IDLE_REG) wsel_cnt++;
    if (bus.done) begin
      done_cnt++;
      done_at = cyc;
    end
    if ((bus.start_save || bus.start_restore) && !bus.busy && !RST)
      start_at = cyc;
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go(input bit sv, input bit rs, input logic [15:0] b);
    bus.start_save    = sv;
    bus.start_restore = rs;
    bus.base_addr     = b;
    @(negedge CLK);
    bus.start_save    = 1'b0;
    bus.start_restore = 1'b0;
  endtask

  task automatic wait_done(input int base_cnt, input int lim);
    int k = 0;
    while (done_cnt == base_cnt && k < lim) begin
      @(negedge CLK);
      k++;
    end
    chk("done_timeout", 32'(done_cnt != base_cnt), 1);
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    bus.start_save    = 1'b0;
    bus.start_restore = 1'b0;
    bus.base_addr     = '0;
    bus.mem_ready     = 1'b1;
    repeat (3) @(negedge CLK);

    chk("rst_busy",     32'(bus.busy), 0);
    chk("rst_done",     32'(bus.done), 0);
    chk("rst_mem_wr",   32'(bus.mem_wr), 0);
    chk("rst_mem_rd",   32'(bus.mem_rd), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_wdata",    32'(bus.mem_wr_data), 0);
    chk("rst_rd_sel",   32'(bus.reg_rd_sel), 0);
    chk("rst_wr_sel",   32'(bus.reg_wr_sel), 31);
    chk("rst_wr_data",  32'(bus.reg_wr_data), 0);

    rf_pre = 1'b1;
    mem_pre = 1'b1;
    @(negedge CLK);
    rf_pre = 1'b0;
    mem_pre = 1'b0;
    RST = 1'b0;
    @(negedge CLK);

    s0 = st_addr.size(); d0 = done_cnt; w0 = wsel_cnt;
    go(1'b1, 1'b0, 16'h0200);
    wait_done(d0, 200);
    chk("sv_count", 32'(st_addr.size() - s0), 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("sv_addr%0d", i), 32'(st_addr[s0 + i]), 32'h0200 + i);
      chk($sformatf("sv_data%0d", i), 32'(st_data[s0 + i]), 32'h1000 + i);
    end
    chk("sv_latency", 32'(done_at - start_at), 49);
    chk("sv_wr_sel",  32'(wsel_cnt - w0), 0);
    chk("sv_done1",   32'(done_cnt - d0), 1);

    d0 = done_cnt; w0 = wsel_cnt;
    go(1'b0, 1'b1, 16'h0300);
    wait_done(d0, 200);
    chk("rs_latency", 32'(done_at - start_at), 49);
    chk("rs_wr_sel",  32'(wsel_cnt - w0), 16);
    chk("rs_done1",   32'(done_cnt - d0), 1);
    for (int i = 0; i < 16; i++)
      chk($sformatf("rs_r%0d", i), 32'(rf[i]), 32'hA000 + i);

    s0 = st_addr.size(); d0 = done_cnt;
    go(1'b1, 1'b0, 16'h0200);
    n = 0;
    while (!(bus.mem_wr && (st_addr.size() - s0 == 4)) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("bp_reach", 32'(n < 100), 1);
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_wr%0d", k),   32'(bus.mem_wr), 1);
      chk($sformatf("bp_addr%0d", k), 32'(bus.mem_addr), 32'h0204);
      chk($sformatf("bp_data%0d", k), 32'(bus.mem_wr_data), 32'hA004);
      @(negedge CLK);
    end
    bus.mem_ready = 1'b1;
    wait_done(d0, 200);
    chk("bp_latency", 32'(done_at - start_at), 52);
    chk("bp_count",   32'(st_addr.size() - s0), 16);
    chk("bp_addr4",   32'(st_addr[s0 + 4]), 32'h0204);

    s0 = st_addr.size(); d0 = done_cnt; w0 = wsel_cnt; r0 = rd_cnt;
    go(1'b1, 1'b1, 16'hFFFE);
    repeat (8) @(negedge CLK);
    go(1'b0, 1'b1, 16'h1234);
    wait_done(d0, 200);
    chk("wr_count",   32'(st_addr.size() - s0), 16);
    chk("wr_addr0",   32'(st_addr[s0]), 32'hFFFE);
    chk("wr_addr1",   32'(st_addr[s0 + 1]), 32'hFFFF);
    chk("wr_addr2",   32'(st_addr[s0 + 2]), 32'h0000);
    chk("wr_addr15",  32'(st_addr[s0 + 15]), 32'h000D);
    chk("wr_data0",   32'(st_data[s0]), 32'hA000);
    chk("wr_no_rd",   32'(rd_cnt - r0), 0);
    chk("wr_no_wsel", 32'(wsel_cnt - w0), 0);
    chk("wr_done1",   32'(done_cnt - d0), 1);
    chk("wr_latency", 32'(done_at - start_at), 49);

    d0 = done_cnt; w0 = wsel_cnt;
    go(1'b0, 1'b1, 16'h0300);
    n = 0;
    while (!(bus.mem_rd && (wsel_cnt - w0 == 6)) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("ar_reach", 32'(n < 100), 1);
    RST = 1'b1;
    @(negedge CLK);
    chk("ar_busy",   32'(bus.busy), 0);
    chk("ar_mem_rd", 32'(bus.mem_rd), 0);
    chk("ar_wr_sel", 32'(bus.reg_wr_sel), 31);
    chk("ar_done",   32'(bus.done), 0);
    RST = 1'b0;
    repeat (60) @(negedge CLK);
    chk("ar_no_done",  32'(done_cnt - d0), 0);
    chk("ar_wr_count", 32'(wsel_cnt - w0), 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
